// File: rtl/dma_fir_seq_pkg.sv
// rtl/dma_fir_seq_pkg.sv - shared constants, state enum and descriptor layout for the DMA/FIR job sequencer
package dma_fir_seq_pkg;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_INIT   = 3'd1;
   localparam logic [2:0] ADDR_RADDR  = 3'd2;
   localparam logic [2:0] ADDR_WADDR  = 3'd3;
   localparam logic [2:0] ADDR_LEN    = 3'd4;
   localparam logic [2:0] ADDR_STATUS = 3'd5;

   localparam int CTRL_START    = 0;
   localparam int CTRL_CLRI     = 1;
   localparam int CTRL_CLRO     = 4;
   localparam int CTRL_MODE_LSB = 8;
   localparam int STATUS_DONE   = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_CFG,
      ST_GO,
      ST_PREQ,
      ST_PWAIT,
      ST_FIN,
      ST_ERR
   } seq_state_t;

   // The job id travels beside this body in the queue, since its width is a top-level parameter.
   typedef struct packed {
      logic [1:0]  mode;
      logic [31:0] len;
      logic [31:0] wr_addr;
      logic [31:0] rd_addr;
      logic [31:0] init;
   } desc_body_t;

   function automatic logic [31:0] ctrl_word(input logic [1:0] mode, input logic start, input logic clr);
      logic [31:0] w;
      w = '0;
      w[CTRL_MODE_LSB +: 2] = mode;
      w[CTRL_START]         = start;
      w[CTRL_CLRI]          = clr;
      w[CTRL_CLRO]          = clr;
      return w;
   endfunction

endpackage

// File: rtl/dma_fir_desc_fifo.sv
// rtl/dma_fir_desc_fifo.sv - synchronous descriptor queue with full/empty/level
module dma_fir_desc_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    push,
   input  logic [DW-1:0]           push_data,
   input  logic                    pop,
   output logic [DW-1:0]           pop_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop & ~empty;
   // A simultaneous pop frees the slot this push lands in.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      level <= level + 1'b1;
         else if (do_pop && !do_push) level <= level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (level == DEPTH[AW:0]);
   assign empty    = (level == '0);

endmodule

// File: rtl/dma_fir_job_sequencer.sv
// rtl/dma_fir_job_sequencer.sv - programs the DMA/FIR control port job by job from a descriptor queue
module dma_fir_job_sequencer
   import dma_fir_seq_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 65535,
   parameter int IDW     = 4
) (
   input  logic                    iClk,
   input  logic                    iRstn,
   input  logic                    iDescValid,
   output logic                    oDescReady,
   input  logic [31:0]             iDescInit,
   input  logic [31:0]             iDescRdAddr,
   input  logic [31:0]             iDescWrAddr,
   input  logic [31:0]             iDescLen,
   input  logic [1:0]              iDescMode,
   input  logic [IDW-1:0]          iDescId,
   input  logic                    iAbort,
   output logic                    oCs,
   output logic                    oWr,
   output logic                    oRd,
   output logic [2:0]              oAddr,
   output logic [31:0]             oWData,
   input  logic [31:0]             iRData,
   output logic                    oJobDone,
   output logic [IDW-1:0]          oJobId,
   output logic                    oJobErr,
   output logic                    oBusy,
   output logic [$clog2(DEPTH):0]  oQueueLevel
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int FW = $bits(desc_body_t) + IDW;

   seq_state_t     state;
   seq_state_t     state_nxt;
   desc_body_t     work;
   desc_body_t     in_body;
   logic [IDW-1:0] work_id;
   logic [IDW-1:0] last_id;
   logic [1:0]     cfg_cnt;
   logic [TW-1:0]  tmo_cnt;
   logic           armed;
   logic           tmo_hit;
   logic           done_bit;
   logic           abortable;
   logic           pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [FW-1:0]  fifo_out;
   logic           status_unused;

   assign in_body = '{mode: iDescMode, len: iDescLen, wr_addr: iDescWrAddr,
                      rd_addr: iDescRdAddr, init: iDescInit};

   assign pop        = (state == ST_IDLE) & ~fifo_empty;
   assign oDescReady = ~fifo_full | pop;

   dma_fir_desc_fifo #(
      .DEPTH (DEPTH),
      .DW    (FW)
   ) u_fifo (
      .clk       (iClk),
      .rstn      (iRstn),
      .push      (iDescValid & oDescReady),
      .push_data ({in_body, iDescId}),
      .pop       (pop),
      .pop_data  (fifo_out),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (oQueueLevel)
   );

   assign done_bit      = iRData[STATUS_DONE];
   assign status_unused = ^{iRData[31:STATUS_DONE+1], iRData[STATUS_DONE-1:0]};
   assign tmo_hit       = (tmo_cnt <= TW'(1));
   assign abortable     = (state == ST_CLR) | (state == ST_CFG) | (state == ST_GO) |
                          (state == ST_PREQ) | (state == ST_PWAIT);

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         state   <= ST_IDLE;
         work    <= '0;
         work_id <= '0;
         last_id <= '0;
         cfg_cnt <= '0;
         tmo_cnt <= '0;
         armed   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (pop) {work, work_id} <= fifo_out;
         cfg_cnt <= (state == ST_CFG) ? cfg_cnt + 1'b1 : 2'd0;
         if (state == ST_GO) begin
            tmo_cnt <= TIMEOUT[TW-1:0];
            armed   <= 1'b0;
         end else if ((state == ST_PREQ || state == ST_PWAIT) && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
         end
         // A done flag only counts once it has been seen low for this job.
         if (state == ST_PWAIT && !done_bit) armed <= 1'b1;
         if (state == ST_FIN || state == ST_ERR) last_id <= work_id;
      end
   end

   always_comb begin
      state_nxt = state;
      oCs       = 1'b0;
      oWr       = 1'b0;
      oRd       = 1'b0;
      oAddr     = ADDR_CTRL;
      oWData    = '0;
      case (state)
         ST_IDLE: if (!fifo_empty) state_nxt = ST_CLR;
         ST_CLR: begin
            oCs       = 1'b1;
            oWr       = 1'b1;
            oWData    = ctrl_word(work.mode, 1'b0, 1'b1);
            state_nxt = ST_CFG;
         end
         ST_CFG: begin
            oCs   = 1'b1;
            oWr   = 1'b1;
            oAddr = ADDR_INIT + {1'b0, cfg_cnt};
            case (cfg_cnt)
               2'd0:    oWData = work.init;
               2'd1:    oWData = work.rd_addr;
               2'd2:    oWData = work.wr_addr;
               default: oWData = work.len;
            endcase
            if (cfg_cnt == 2'd3) state_nxt = ST_GO;
         end
         ST_GO: begin
            oCs       = 1'b1;
            oWr       = 1'b1;
            oWData    = ctrl_word(work.mode, 1'b1, 1'b0);
            state_nxt = ST_PREQ;
         end
         ST_PREQ: begin
            oCs       = 1'b1;
            oRd       = 1'b1;
            oAddr     = ADDR_STATUS;
            state_nxt = tmo_hit ? ST_ERR : ST_PWAIT;
         end
         ST_PWAIT: begin
            if (done_bit && armed) state_nxt = ST_FIN;
            else if (tmo_hit)      state_nxt = ST_ERR;
            else                   state_nxt = ST_PREQ;
         end
         ST_FIN: state_nxt = ST_IDLE;
         ST_ERR: begin
            oCs       = 1'b1;
            oWr       = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (iAbort && abortable) begin
         state_nxt = ST_ERR;
         oCs       = 1'b0;
         oWr       = 1'b0;
         oRd       = 1'b0;
      end
   end

   assign oJobDone = (state == ST_FIN) | (state == ST_ERR);
   assign oJobErr  = (state == ST_ERR);
   assign oJobId   = oJobDone ? work_id : last_id;
   assign oBusy    = (state != ST_IDLE);

endmodule

// File: tb/tb_dma_fir_job_sequencer.sv
// tb/tb_dma_fir_job_sequencer.sv - scoreboard bench for the DMA/FIR job sequencer
module tb_dma_fir_job_sequencer;

   localparam int DEPTH = 4;
   localparam int TMO   = 50;
   localparam int IDW   = 4;

   logic           iClk = 1'b0;
   logic           iRstn = 1'b0;
   logic           iDescValid = 1'b0;
   logic           oDescReady;
   logic [31:0]    iDescInit = '0;
   logic [31:0]    iDescRdAddr = '0;
   logic [31:0]    iDescWrAddr = '0;
   logic [31:0]    iDescLen = '0;
   logic [1:0]     iDescMode = '0;
   logic [IDW-1:0] iDescId = '0;
   logic           iAbort = 1'b0;
   logic           oCs, oWr, oRd;
   logic [2:0]     oAddr;
   logic [31:0]    oWData;
   logic [31:0]    iRData = '0;
   logic           oJobDone;
   logic [IDW-1:0] oJobId;
   logic           oJobErr;
   logic           oBusy;
   logic [2:0]     oQueueLevel;

   dma_fir_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TMO), .IDW(IDW)) dut (
      .iClk(iClk), .iRstn(iRstn), .iDescValid(iDescValid), .oDescReady(oDescReady),
      .iDescInit(iDescInit), .iDescRdAddr(iDescRdAddr), .iDescWrAddr(iDescWrAddr),
      .iDescLen(iDescLen), .iDescMode(iDescMode), .iDescId(iDescId), .iAbort(iAbort),
      .oCs(oCs), .oWr(oWr), .oRd(oRd), .oAddr(oAddr), .oWData(oWData), .iRData(iRData),
      .oJobDone(oJobDone), .oJobId(oJobId), .oJobErr(oJobErr), .oBusy(oBusy),
      .oQueueLevel(oQueueLevel)
   );

   always #5 iClk = ~iClk;

   // kind: 0 = done after n zero polls, 1 = stale done (1,0,1), 2 = never done
   typedef struct { int id; int err; int reads; int gap; } done_t;
   typedef struct { int kind; int n; } job_t;

   logic [34:0] exp_wr[$];
   done_t       exp_done[$];
   job_t        job_q[$];

   int   compared = 0;
   int   mismatched = 0;
   int   cyc = 0;
   int   reads = 0;
   int   go_cyc = 0;
   int   poll_idx = 0;
   int   last_id = 0;
   job_t cur = '{2, 0};
   logic rd_pending = 1'b0;
   logic chk_idle = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every bus write and completion against the queued expectations.
   always @(negedge iClk) begin
      done_t       d;
      logic [34:0] e;
      cyc++;
      if (iRstn) begin
         if (chk_idle) begin
            chk("busy_after_done", oBusy, 0);
            chk("job_id_hold", oJobId, last_id);
            chk_idle = 1'b0;
         end
         rd_pending = oCs & oRd;
         if (oCs && oRd) begin
            reads++;
            chk("read_addr", oAddr, 5);
         end
         if (oCs && oWr) begin
            if (exp_wr.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_write: addr %0d data %0h with none expected", oAddr, oWData);
            end else begin
               e = exp_wr.pop_front();
               chk("write", {oAddr, oWData}, e);
            end
            if (oAddr == 3'd0 && oWData[0]) begin
               go_cyc   = cyc;
               reads    = 0;
               poll_idx = 0;
               cur      = (job_q.size() != 0) ? job_q.pop_front() : '{2, 0};
            end
         end
         if (oJobDone) begin
            if (exp_done.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_done: id %0d err %0d with none expected", oJobId, oJobErr);
            end else begin
               d = exp_done.pop_front();
               chk("done_id", oJobId, d.id);
               chk("done_err", oJobErr, d.err);
               if (d.reads >= 0) chk("poll_reads", reads, d.reads);
               if (d.gap != 0) chk("timeout_gap_in_range", ((cyc - go_cyc) >= 45) && ((cyc - go_cyc) <= 55), 1);
               last_id = d.id;
            end
            chk_idle = 1'b1;
         end
      end else begin
         rd_pending = 1'b0;
         chk_idle   = 1'b0;
      end
   end

   // Core status model: registered read data one cycle after the read strobe.
   initial forever begin
      logic [31:0] r;
      logic        b;
      @(posedge iClk);
      #1;
      if (rd_pending) begin
         case (cur.kind)
            0:       b = (poll_idx >= cur.n);
            1:       b = (poll_idx != 1);
            default: b = 1'b0;
         endcase
         r      = $urandom;
         r[7]   = b;
         iRData = r;
         poll_idx++;
      end
   end

   task automatic exp_job(input logic [31:0] init, input logic [31:0] ra, input logic [31:0] wa,
                          input logic [31:0] len, input logic [1:0] mode, input int fate);
      exp_wr.push_back({3'd0, 32'h12 | (32'(mode) << 8)});
      exp_wr.push_back({3'd1, init});
      exp_wr.push_back({3'd2, ra});
      if (fate == 2) begin
         exp_wr.push_back({3'd0, 32'h0});
         return;
      end
      exp_wr.push_back({3'd3, wa});
      exp_wr.push_back({3'd4, len});
      exp_wr.push_back({3'd0, 32'h1 | (32'(mode) << 8)});
      if (fate == 1) exp_wr.push_back({3'd0, 32'h0});
   endtask

   // fate: 0 = completes, 1 = times out, 2 = aborted after the address-2 write
   task automatic expect_job(input logic [31:0] init, input logic [31:0] ra, input logic [31:0] wa,
                             input logic [31:0] len, input logic [1:0] mode, input int id,
                             input int fate, input int kind, input int n);
      done_t d;
      exp_job(init, ra, wa, len, mode, fate);
      if (fate != 2) job_q.push_back('{kind, n});
      d.id    = id;
      d.err   = (fate != 0) ? 1 : 0;
      d.reads = (fate != 0) ? -1 : ((kind == 1) ? 3 : n + 1);
      d.gap   = (fate == 1) ? 1 : 0;
      exp_done.push_back(d);
   endtask

   task automatic set_fields(input logic [31:0] init, input logic [31:0] ra, input logic [31:0] wa,
                             input logic [31:0] len, input logic [1:0] mode, input int id);
      iDescInit = init; iDescRdAddr = ra; iDescWrAddr = wa;
      iDescLen = len; iDescMode = mode; iDescId = IDW'(id);
   endtask

   task automatic submit(input logic [31:0] init, input logic [31:0] ra, input logic [31:0] wa,
                         input logic [31:0] len, input logic [1:0] mode, input int id,
                         input int fate, input int kind, input int n);
      expect_job(init, ra, wa, len, mode, id, fate, kind, n);
      @(posedge iClk);
      #1;
      set_fields(init, ra, wa, len, mode, id);
      iDescValid = 1'b1;
      @(posedge iClk);
      #1;
      iDescValid = 1'b0;
   endtask

   task automatic submit_rand(input int id, input int kind);
      submit($urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), id, 0, kind,
             $urandom_range(1, 12));
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while ((exp_done.size() != 0 || exp_wr.size() != 0) && t < 2000) begin
         @(negedge iClk);
         t++;
      end
      chk({name, "_drained"}, (exp_done.size() == 0) && (exp_wr.size() == 0), 1);
      exp_done.delete();
      exp_wr.delete();
      repeat (2) @(negedge iClk);
   endtask

   task automatic wait_reads(input int count, output int seen);
      seen = 0;
      for (int t = 0; t < 300 && seen < count; t++) begin
         @(negedge iClk);
         if (oCs && oRd) seen++;
      end
   endtask

   initial begin
      int seen;
      int lvl;
      logic found;

      repeat (3) @(negedge iClk);
      chk("rst_ready", oDescReady, 1);
      chk("rst_level", oQueueLevel, 0);
      chk("rst_bus", {oCs, oWr, oRd, oJobDone, oBusy, oJobErr}, 0);
      iRstn = 1'b1;
      @(negedge iClk);
      chk("idle_busy", oBusy, 0);
      chk("idle_jobid", oJobId, 0);

      // Directed single job
      submit(32'h10, 32'h1000, 32'h2000, 32'h40, 2'd2, 3, 0, 0, 20);
      wait_drain("single");

      // Stale done on the first poll
      submit(32'h55, 32'h3000, 32'h4000, 32'h80, 2'd1, 5, 0, 1, 0);
      wait_drain("stale");

      // Queue fill while a long job is polling
      submit(32'h1, 32'h2, 32'h3, 32'h4, 2'd0, 8, 0, 0, 20);
      wait_reads(1, seen);
      chk("long_job_polling", seen, 1);
      lvl = 0;
      @(posedge iClk);
      #1;
      for (int i = 0; i < 5; i++) begin
         logic [31:0] f0, f1, f2, f3;
         logic [1:0]  m;
         f0 = $urandom; f1 = $urandom; f2 = $urandom; f3 = $urandom; m = 2'($urandom_range(0, 3));
         set_fields(f0, f1, f2, f3, m, i);
         iDescValid = 1'b1;
         @(negedge iClk);
         chk("fill_ready", oDescReady, (lvl < DEPTH) ? 1 : 0);
         chk("fill_level", oQueueLevel, lvl);
         if (lvl < DEPTH) begin
            expect_job(f0, f1, f2, f3, m, i, 0, 0, $urandom_range(1, 8));
            lvl++;
         end
         @(posedge iClk);
         #1;
      end
      iDescValid = 1'b0;
      @(negedge iClk);
      chk("full_level", oQueueLevel, 4);
      chk("full_ready", oDescReady, 0);
      wait_drain("queue");

      // Timeout, followed by a normal job
      submit(32'hA, 32'hB, 32'hC, 32'hD, 2'd3, 6, 1, 2, 0);
      submit(32'hE, 32'hF, 32'h11, 32'h22, 2'd1, 7, 0, 0, 5);
      wait_drain("timeout");

      // Abort during configuration
      submit(32'h77, 32'h88, 32'h99, 32'hAA, 2'd2, 9, 2, 0, 0);
      found = 1'b0;
      for (int t = 0; t < 50 && !found; t++) begin
         @(negedge iClk);
         if (oCs && oWr && oAddr == 3'd2) found = 1'b1;
      end
      chk("abort_addr2_seen", found, 1);
      @(posedge iClk);
      #1;
      iAbort = 1'b1;
      @(posedge iClk);
      #1;
      iAbort = 1'b0;
      wait_drain("abort");

      // Abort while idle is ignored
      @(posedge iClk);
      #1;
      iAbort = 1'b1;
      @(negedge iClk);
      chk("idle_abort_busy", oBusy, 0);
      @(posedge iClk);
      #1;
      iAbort = 1'b0;
      repeat (3) @(negedge iClk);
      chk("idle_abort_after", oBusy, 0);

      // Randomised batches
      for (int r = 0; r < 2; r++) begin
         for (int j = 0; j < 3; j++) submit_rand($urandom_range(0, 15), $urandom_range(0, 1));
         wait_drain("random");
      end

      // Reset mid-poll
      submit(32'h1, 32'h2, 32'h3, 32'h4, 2'd1, 1, 1, 2, 0);
      submit_rand(2, 0);
      submit_rand(4, 0);
      wait_reads(3, seen);
      chk("reset_poll_reached", seen, 3);
      @(negedge iClk);
      chk("level_before_reset", oQueueLevel, 2);
      @(posedge iClk);
      #3;
      iRstn = 1'b0;
      exp_wr.delete();
      exp_done.delete();
      job_q.delete();
      #1;
      chk("mid_rst_bus", {oCs, oWr, oRd, oJobDone, oBusy, oJobErr}, 0);
      chk("mid_rst_ready", oDescReady, 1);
      chk("mid_rst_level", oQueueLevel, 0);
      chk("mid_rst_jobid", oJobId, 0);
      repeat (2) @(negedge iClk);
      iRstn = 1'b1;
      last_id = 0;
      repeat (80) @(negedge iClk);
      chk("post_rst_busy", oBusy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
